if_id_pipe_reg: RTL and testbench
=================================

Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline stage register for the RISC-V core. It replaces the fixed 8-bit instruction latch with a valid/ready handshake stage that carries the instruction and PC. A 2-entry skid buffer lets the fetch side see a fully registered ready, with no combinational path from out_ready to in_ready. It also supports flush by bubble insertion and keeps a saturating stall counter for performance analysis.

Parameters:
INSTR_W, 32, instruction width in bits.
PC_W, 32, program counter width in bits.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0); width INSTR_W.
CNT_W, 16, stall counter width.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  stage can accept; registered, equals NOT skid_valid.
in_instr  input  INSTR_W  fetched instruction.
in_pc  input  PC_W  PC of in_instr.
flush  input  1  synchronous kill of all held entries (branch taken or trap).
out_valid  output  1  decode-side entry valid.
out_ready  input  1  decode accepts the entry this cycle.
out_instr  output  INSTR_W  instruction to decode; NOP_INSTR when not valid.
out_pc  output  PC_W  PC to decode.
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - out_instr=NOP_INSTR, out_pc=0, stall_cnt=0; skid contents=0.
- Handshakes:
  - acc = in_valid & in_ready.
  - deq = out_valid & out_ready.
- States, derived from {main_valid, skid_valid}:
  - EMPTY = 00, FULL = 10, SKID = 11; state 01 is illegal.
- EMPTY:
  - acc -> load main, go to FULL.
  - Otherwise hold.
- FULL:
  - acc & deq -> load main with input, stay FULL (throughput 1/cycle).
  - deq only -> EMPTY; out_instr becomes NOP_INSTR.
  - acc only -> input goes to skid, go to SKID.
  - Neither -> hold.
- SKID (in_ready=0, so acc cannot occur):
  - deq -> main <= skid, go to FULL.
  - Otherwise hold.
- Latency: one cycle from acc to out_valid when EMPTY.
- Ordering: strict FIFO order. An entry is never dropped or duplicated except by flush.
- Flush (synchronous, highest priority):
  - Next state is EMPTY, out_instr=NOP_INSTR.
  - out_pc holds its last value.
  - An acc in the flush cycle is consumed and discarded; the fetch side treats it as taken.
  - A deq in the flush cycle still completes at the output; decode qualifies it with its own kill.
- out_instr is driven from a register, never combinationally from in_instr.
- stall_cnt:
  - Increments when out_valid & ~out_ready & ~flush.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- Reset asserted mid-transfer aborts immediately; all entries are lost.
- Widths: no arithmetic on the datapath; PC is passed through unmodified.

Test Plan:
1. Reset, then in_valid=1 with instr=32'h00500093, pc=32'h100, out_ready=1 -> next cycle out_valid=1, out_instr=32'h00500093, out_pc=32'h100; in_ready stays 1.
2. Streaming: 8 consecutive instrs (pc 0x0..0x1C), out_ready=1 -> one output per cycle, in order, no bubbles.
3. Backpressure: out_ready=0 while sending A(pc 0x20) then B(pc 0x24).
   - B lands in skid and in_ready=0 the following cycle.
   - Raise out_ready -> A then B appear on consecutive cycles, and in_ready returns to 1 after B moves to main.
   - stall_cnt equals the number of cycles out_ready was held low with out_valid=1.
4. Flush in SKID state with in_valid=1 -> next cycle out_valid=0, out_instr=32'h00000013, in_ready=1; neither held entry nor the flushed input ever appears.
5. Saturation (CNT_W=4 override): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF.
6. Assert reset low asynchronously mid-SKID, between clock edges -> out_valid=0, in_ready=1, stall_cnt=0 immediately; after release, accepts a new instr normally.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//
// IF/ID pipeline stage register with a valid/ready handshake on both sides.
// A main entry drives the decode side. A second skid entry absorbs the one
// instruction that fetch may still push in the cycle that decode stalls. This
// makes in_ready a pure register output: it is the inverse of the skid valid
// flag, with no combinational path from out_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   fetch presents in_instr / in_pc
//   in_ready   stage can accept (registered, == ~skid_valid)
//   in_instr   fetched instruction
//   in_pc      PC of in_instr
//   flush      synchronous kill of all held entries (highest priority)
//   out_valid  decode-side entry valid
//   out_ready  decode accepts the entry this cycle
//   out_instr  instruction to decode, NOP_INSTR whenever out_valid is low
//   out_pc     PC to decode (holds its last value when the stage empties)
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int                   INSTR_W   = 32,
    parameter int                   PC_W      = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h0000_0013),
    parameter int                   CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Encoding is {main_valid, skid_valid}; 2'b01 can never be reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } state_t;

    state_t             state_reg, state_next;
    logic [INSTR_W-1:0] main_instr_reg, main_instr_next;
    logic [PC_W-1:0]    main_pc_reg, main_pc_next;
    logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
    logic [PC_W-1:0]    skid_pc_reg, skid_pc_next;
    logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;

    logic main_valid;
    logic skid_valid;
    logic acc;
    logic deq;
    logic stall_inc;
    logic cnt_sat;

    assign main_valid = (state_reg == ST_FULL) || (state_reg == ST_SKID);
    assign skid_valid = (state_reg == ST_SKID);

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_instr = main_instr_reg;
    assign out_pc    = main_pc_reg;
    assign stall_cnt = stall_cnt_reg;

    assign acc = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath steering.
    // main_instr is forced to NOP_INSTR on every transition into EMPTY so
    // that out_instr can come straight from a register. main_pc is only
    // written on a load, so out_pc keeps the last PC across bubbles.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        main_instr_next = main_instr_reg;
        main_pc_next    = main_pc_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;

        if (flush) begin
            // Any accept in this cycle is swallowed; a dequeue has already
            // completed at the output and needs no action here.
            state_next      = ST_EMPTY;
            main_instr_next = NOP_INSTR;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (acc) begin
                        state_next      = ST_FULL;
                        main_instr_next = in_instr;
                        main_pc_next    = in_pc;
                    end
                end
                ST_FULL: begin
                    if (acc && deq) begin
                        main_instr_next = in_instr;
                        main_pc_next    = in_pc;
                    end else if (deq) begin
                        state_next      = ST_EMPTY;
                        main_instr_next = NOP_INSTR;
                    end else if (acc) begin
                        state_next      = ST_SKID;
                        skid_instr_next = in_instr;
                        skid_pc_next    = in_pc;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only a dequeue can happen.
                    if (deq) begin
                        state_next      = ST_FULL;
                        main_instr_next = skid_instr_reg;
                        main_pc_next    = skid_pc_reg;
                    end
                end
                default: begin
                    state_next      = ST_EMPTY;
                    main_instr_next = NOP_INSTR;
                end
            endcase
        end
    end

    // Stall counter: counts decode back-pressure cycles, sticks at all-ones.
    assign stall_inc = out_valid & ~out_ready & ~flush;
    assign cnt_sat   = &stall_cnt_reg;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_inc && !cnt_sat) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_EMPTY;
            main_instr_reg <= NOP_INSTR;
            main_pc_reg    <= '0;
            skid_instr_reg <= '0;
            skid_pc_reg    <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            main_instr_reg <= main_instr_next;
            main_pc_reg    <= main_pc_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_pipe_reg
//
// Directed bench for if_id_pipe_reg. A monitor on the falling edge logs every
// accepted fetch into a scoreboard queue and pops/compares on every decode
// dequeue; flush and reset empty the queue. The main thread issues directed
// vectors and checks hand-computed handshake, bubble and counter values.
// A second instance with CNT_W=4 shares the stimulus to show saturation.
// ---------------------------------------------------------------------------
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [15:0] stall_cnt;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_instr;
    logic [31:0] sat_out_pc;
    logic [3:0]  sat_stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    if_id_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .stall_cnt (stall_cnt)
    );

    if_id_pipe_reg #(.CNT_W(4)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_instr (sat_out_instr),
        .out_pc    (sat_out_pc),
        .stall_cnt (sat_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: dequeue compare first, then flush/accept update,
    // matching the order the DUT resolves these in one cycle.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL deq_unexpected: got pc=%h instr=%h expected none", out_pc, out_instr);
                end else begin
                    logic [63:0] e;
                    e = sb_q.pop_front();
                    $display("deq pc=%h instr=%h", out_pc, out_instr);
                    chk("deq_instr", {32'h0, out_instr}, {32'h0, e[63:32]});
                    chk("deq_pc", {32'h0, out_pc}, {32'h0, e[31:0]});
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back({in_instr, in_pc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] stream_tbl [8];

    initial begin
        stream_tbl[0] = 32'h0010_0093; stream_tbl[1] = 32'h0020_0113;
        stream_tbl[2] = 32'h0030_0193; stream_tbl[3] = 32'h0040_0213;
        stream_tbl[4] = 32'h0050_0293; stream_tbl[5] = 32'h0060_0313;
        stream_tbl[6] = 32'h0070_0393; stream_tbl[7] = 32'h0080_0413;

        reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_out_instr", {32'h0, out_instr}, {32'h0, NOP});
        chk("rst_out_pc", {32'h0, out_pc}, 64'h0);
        chk("rst_stall_cnt", {48'h0, stall_cnt}, 64'h0);
        chk("rst_sat_state", {26'h0, sat_in_ready, sat_out_valid, sat_out_instr, sat_stall_cnt},
            {26'h0, 1'b1, 1'b0, NOP, 4'h0});
        chk("rst_sat_pc", {32'h0, sat_out_pc}, 64'h0);
        reset = 1'b1;
        tick();

        // 1: single instruction, one-cycle latency
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", {63'h0, out_valid}, 64'h1);
        chk("t1_out_instr", {32'h0, out_instr}, 64'h0050_0093);
        chk("t1_out_pc", {32'h0, out_pc}, 64'h100);
        chk("t1_in_ready", {63'h0, in_ready}, 64'h1);
        tick();
        chk("t1_empty_valid", {63'h0, out_valid}, 64'h0);
        chk("t1_empty_nop", {32'h0, out_instr}, {32'h0, NOP});
        chk("t1_pc_hold", {32'h0, out_pc}, 64'h100);

        // 2: streaming, one output per cycle with no bubbles
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = stream_tbl[i]; in_pc = 32'(i * 4);
            tick();
            chk("t2_valid", {63'h0, out_valid}, 64'h1);
            chk("t2_pc", {32'h0, out_pc}, 64'(i * 4));
            chk("t2_instr", {32'h0, out_instr}, {32'h0, stream_tbl[i]});
        end
        in_valid = 1'b0;
        tick();
        chk("t2_drain", {63'h0, out_valid}, 64'h0);

        // 3: back-pressure into the skid entry
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0020_8133; in_pc = 32'h20;
        tick();
        chk("t3_a_in_ready", {63'h0, in_ready}, 64'h1);
        chk("t3_a_cnt", {48'h0, stall_cnt}, 64'h0);
        in_instr = 32'h0030_81b3; in_pc = 32'h24;
        tick();
        in_valid = 1'b0;
        chk("t3_skid_in_ready", {63'h0, in_ready}, 64'h0);
        chk("t3_skid_pc", {32'h0, out_pc}, 64'h20);
        chk("t3_cnt1", {48'h0, stall_cnt}, 64'h1);
        tick(); tick();
        chk("t3_cnt3", {48'h0, stall_cnt}, 64'h3);
        chk("t3_hold_in_ready", {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1;
        tick();
        chk("t3_b_main_pc", {32'h0, out_pc}, 64'h24);
        chk("t3_b_main_instr", {32'h0, out_instr}, 64'h0030_81b3);
        chk("t3_b_in_ready", {63'h0, in_ready}, 64'h1);
        tick();
        chk("t3_done_valid", {63'h0, out_valid}, 64'h0);
        chk("t3_cnt_final", {48'h0, stall_cnt}, 64'h3);

        // 4: flush while SKID with a pending fetch
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0040_0013; in_pc = 32'h40;
        tick();
        in_instr = 32'h0050_0013; in_pc = 32'h44;
        tick();
        chk("t4_skid", {63'h0, in_ready}, 64'h0);
        in_instr = 32'h0060_0013; in_pc = 32'h48; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_valid", {63'h0, out_valid}, 64'h0);
        chk("t4_nop", {32'h0, out_instr}, {32'h0, NOP});
        chk("t4_in_ready", {63'h0, in_ready}, 64'h1);
        chk("t4_pc_hold", {32'h0, out_pc}, 64'h40);
        chk("t4_cnt", {48'h0, stall_cnt}, 64'h4);
        // flush with an accept from EMPTY: input is discarded
        in_valid = 1'b1; in_instr = 32'h0070_0013; in_pc = 32'h4c; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t4_acc_dropped", {63'h0, out_valid}, 64'h0);
        tick(); tick();
        chk("t4_idle", {63'h0, out_valid}, 64'h0);

        // 5: counter saturation on the CNT_W=4 instance (starts at 4)
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0080_0013; in_pc = 32'h50;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) chk("t5_sat_14", {60'h0, sat_stall_cnt}, 64'he);
            if (i == 11) chk("t5_sat_15", {60'h0, sat_stall_cnt}, 64'hf);
        end
        chk("t5_sat_hold", {60'h0, sat_stall_cnt}, 64'hf);
        chk("t5_wide_cnt", {48'h0, stall_cnt}, 64'd24);
        chk("t5_sat_valid", {63'h0, sat_out_valid}, 64'h1);

        // 6: asynchronous reset in the middle of SKID
        in_valid = 1'b1; in_instr = 32'h0090_0013; in_pc = 32'h54;
        tick();
        in_valid = 1'b0;
        chk("t6_skid", {63'h0, in_ready}, 64'h0);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", {63'h0, out_valid}, 64'h0);
        chk("t6_in_ready", {63'h0, in_ready}, 64'h1);
        chk("t6_cnt", {48'h0, stall_cnt}, 64'h0);
        chk("t6_sat_cnt", {60'h0, sat_stall_cnt}, 64'h0);
        chk("t6_nop", {32'h0, out_instr}, {32'h0, NOP});
        chk("t6_pc", {32'h0, out_pc}, 64'h0);
        tick();
        reset = 1'b1;
        tick();
        in_valid = 1'b1; in_instr = 32'h00a0_0093; in_pc = 32'h60; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t6_new_valid", {63'h0, out_valid}, 64'h1);
        chk("t6_new_instr", {32'h0, out_instr}, 64'h00a0_0093);
        chk("t6_new_pc", {32'h0, out_pc}, 64'h60);
        tick();
        chk("t6_new_drain", {63'h0, out_valid}, 64'h0);
        tick();
        chk("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
